// File: rtl/store_generator.sv
// store_generator: memory-stage store-data formatter.
// Aligns the rs2 value onto the byte lanes selected by the store width and
// low address bits, and produces byte enables plus a misalignment flag.
// Every output is registered, so results appear exactly one cycle after the
// request is sampled.
//
// Handshake: I_valid marks a store request in the cycle it is high. There is
// no ready and no backpressure, so a request is accepted on every non-reset
// rising edge. O_valid is I_valid delayed one cycle and qualifies O_data and
// O_byte_en. O_data is formatted and registered whether or not a request is
// present. O_byte_en and O_misaligned are held at zero when no request is
// present.
module store_generator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    input  logic [2:0]  I_storesel,
    input  logic [1:0]  I_addr,
    input  logic [31:0] I_data,
    output logic        O_valid,
    output logic [31:0] O_data,
    output logic [3:0]  O_byte_en,
    output logic        O_misaligned
);

    // Store width encodings (same values as storegen.vh).
    localparam logic [2:0] STORE_SB = 3'd0;
    localparam logic [2:0] STORE_SH = 3'd1;
    localparam logic [2:0] STORE_SW = 3'd2;

    // The lane arithmetic below assumes a four-byte word.
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("store_generator: only DATA_WIDTH=32 is supported");
    end

    logic [31:0] fmt_data;
    logic [3:0]  fmt_be;
    logic        fmt_bad;

    logic        valid_d, valid_q;
    logic [31:0] data_d, data_q;
    logic [3:0]  be_d, be_q;
    logic        mis_d, mis_q;

    // Lane alignment of the source data for the requested width and offset.
    // Lanes not written stay zero. Illegal requests yield zero data and no lanes.
    always_comb begin
        fmt_data = 32'h0;
        fmt_be   = 4'b0000;
        fmt_bad  = 1'b0;
        case (I_storesel)
            STORE_SB: begin
                fmt_data = {24'h0, I_data[7:0]} << {I_addr, 3'b000};
                fmt_be   = 4'b0001 << I_addr;
            end
            STORE_SH: begin
                if (I_addr[0]) begin
                    fmt_bad = 1'b1;
                end else begin
                    fmt_data = {16'h0, I_data[15:0]} << {I_addr, 3'b000};
                    fmt_be   = 4'b0011 << I_addr;
                end
            end
            STORE_SW: begin
                if (I_addr != 2'd0) begin
                    fmt_bad = 1'b1;
                end else begin
                    fmt_data = I_data;
                    fmt_be   = 4'b1111;
                end
            end
            default: begin
                fmt_bad = 1'b1;
            end
        endcase
    end

    // Next-state values. Enables and the error flag only mean something
    // when a request is present, so they are masked by I_valid.
    always_comb begin
        valid_d = I_valid;
        data_d  = fmt_data;
        be_d    = I_valid ? fmt_be : 4'b0000;
        mis_d   = I_valid & fmt_bad;
    end

    // Output registers. Reset wins over a request on the same edge.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            be_q    <= 4'b0000;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
        end
    end

    assign O_valid      = valid_q;
    assign O_data       = data_q;
    assign O_byte_en    = be_q;
    assign O_misaligned = mis_q;

endmodule

// File: tb/tb_store_generator.sv
// Bench for store_generator: directed vectors with hand-computed results.
// The driver pushes each expected output record into a queue; the monitor
// pops one record per cycle on the falling edge and compares.
module tb_store_generator;

  localparam int W = 38; // {valid, misaligned, byte_en[3:0], data[31:0]}

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_sel;
  logic [1:0]  in_addr;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_mis;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  store_generator #(.DATA_WIDTH(32)) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_valid      (in_valid),
    .I_storesel   (in_sel),
    .I_addr       (in_addr),
    .I_data       (in_data),
    .O_valid      (out_valid),
    .O_data       (out_data),
    .O_byte_en    (out_be),
    .O_misaligned (out_mis)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs on a falling edge, then after the rising edge
  // queue the result that edge must have registered
  task automatic apply(input string nm, input logic r, input logic v,
                       input logic [2:0] sel, input logic [1:0] addr,
                       input logic [31:0] data,
                       input logic e_v, input logic e_mis,
                       input logic [3:0] e_be, input logic [31:0] e_data);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_sel   = sel;
    in_addr  = addr;
    in_data  = data;
    @(posedge clk);
    #1;
    exp_q.push_back({e_v, e_mis, e_be, e_data});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {out_valid, out_mis, out_be, out_data};
      n_checks++;
      if (a === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got valid=%b mis=%b be=%b data=%h, want valid=%b mis=%b be=%b data=%h",
                 nm, a[37], a[36], a[35:32], a[31:0], e[37], e[36], e[35:32], e[31:0]);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd2;
    in_addr  = 2'd0;
    in_data  = 32'hFFFF_FFFF;

    // reset for two cycles with arbitrary inputs
    apply("rst0", 1, 1, 3'd2, 2'd0, 32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0);
    apply("rst1", 1, 1, 3'd7, 2'd3, $urandom_range(0, 32'h7FFF_FFFF), 0, 0, 4'b0000, 32'h0);

    // each width at offset 0
    apply("sb_a0", 0, 1, 3'd0, 2'd0, 32'h80808080, 1, 0, 4'b0001, 32'h00000080);
    apply("sh_a0", 0, 1, 3'd1, 2'd0, 32'h80808080, 1, 0, 4'b0011, 32'h00008080);
    apply("sw_a0", 0, 1, 3'd2, 2'd0, 32'h80808080, 1, 0, 4'b1111, 32'h80808080);

    // SB at all offsets
    apply("sb_o0", 0, 1, 3'd0, 2'd0, 32'hDEADBEEF, 1, 0, 4'b0001, 32'h000000EF);
    apply("sb_o1", 0, 1, 3'd0, 2'd1, 32'hDEADBEEF, 1, 0, 4'b0010, 32'h0000EF00);
    apply("sb_o2", 0, 1, 3'd0, 2'd2, 32'hDEADBEEF, 1, 0, 4'b0100, 32'h00EF0000);
    apply("sb_o3", 0, 1, 3'd0, 2'd3, 32'hDEADBEEF, 1, 0, 4'b1000, 32'hEF000000);

    // SH upper half, then misaligned halfword / word
    apply("sh_o2",  0, 1, 3'd1, 2'd2, 32'h1234ABCD, 1, 0, 4'b1100, 32'hABCD0000);
    apply("sh_o1",  0, 1, 3'd1, 2'd1, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);
    apply("sh_o3",  0, 1, 3'd1, 2'd3, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);
    apply("sw_o2",  0, 1, 3'd2, 2'd2, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);
    apply("sw_o1",  0, 1, 3'd2, 2'd1, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);

    // invalid storesel with and without a request
    apply("sel5_v1", 0, 1, 3'd5, 2'd0, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);
    apply("sel5_v0", 0, 0, 3'd5, 2'd0, 32'h1234ABCD, 0, 0, 4'b0000, 32'h0);
    apply("sel3_v1", 0, 1, 3'd3, 2'd0, 32'h1234ABCD, 1, 1, 4'b0000, 32'h0);

    // formatting continues without a request, but no lanes are enabled
    apply("sb_idle", 0, 0, 3'd0, 2'd3, 32'h000000A5, 0, 0, 4'b0000, 32'hA5000000);
    apply("sw_idle", 0, 0, 3'd2, 2'd1, 32'h000000A5, 0, 0, 4'b0000, 32'h0);

    // reset mid-stream drops the word store, the next request goes through
    apply("sw_pre",  0, 1, 3'd2, 2'd0, 32'hCAFEF00D, 1, 0, 4'b1111, 32'hCAFEF00D);
    apply("rst_mid", 1, 1, 3'd2, 2'd0, 32'hCAFEF00D, 0, 0, 4'b0000, 32'h0);
    apply("post_rst", 0, 1, 3'd0, 2'd1, 32'h11223344, 1, 0, 4'b0010, 32'h00004400);
    apply("post_sh", 0, 1, 3'd1, 2'd2, 32'h11223344, 1, 0, 4'b1100, 32'h33440000);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d records left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
